// File: rtl/j_addseq_if.sv
// Request/grant/result bundle between the two requesters and the serial add/sub sequencer.
interface j_addseq_if;
  logic        req_0;
  logic        req_1;
  logic [31:0] a_0;
  logic [31:0] b_0;
  logic [31:0] a_1;
  logic [31:0] b_1;
  logic        sub_0;
  logic        sub_1;
  logic        gnt_0;
  logic        gnt_1;
  logic        ack_0;
  logic        ack_1;
  logic [31:0] q;
  logic        co;
  logic        ovf;
  logic        zero;
  logic        busy;

  modport master (
    output req_0, req_1, a_0, b_0, a_1, b_1, sub_0, sub_1,
    input  gnt_0, gnt_1, ack_0, ack_1, q, co, ovf, zero, busy
  );

  modport slave (
    input  req_0, req_1, a_0, b_0, a_1, b_1, sub_0, sub_1,
    output gnt_0, gnt_1, ack_0, ack_1, q, co, ovf, zero, busy
  );
endinterface

// File: rtl/j_addseq.sv
// Serial 32-bit add/subtract sequencer: one 4-bit ripple adder shared by two
// round-robin requesters, eight nibble passes per operation with a registered carry.
module fa4r (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  always_comb begin
    logic cy;
    s  = '0;
    cy = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end
endmodule

// state | meaning
// IDLE  | waiting for a request; arbiter picks and operands are latched on the edge
// RUN   | eight nibble passes, cnt = 0..7, carry chained through a register
// DONE  | one-cycle ack to the granted requester, results already registered
module j_addseq (
  input  logic       sys_clk,
  input  logic       resetl,
  j_addseq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic [31:0] a_reg, b_reg, result;
  logic        sub_reg, carry;
  logic        last_gnt;
  logic        gnt_0_r, gnt_1_r;
  logic [31:0] q_r;
  logic        co_r, ovf_r, zero_r;

  logic        start, last_pass, pick_1;
  logic [31:0] b_eff, q_new;
  logic [3:0]  sum_nib;
  logic        co_nib;

  assign b_eff = sub_reg ? ~b_reg : b_reg;
  assign q_new = {sum_nib, result[27:0]};

  fa4r u_fa4r (
    .a  (a_reg[{cnt, 2'b00} +: 4]),
    .b  (b_eff[{cnt, 2'b00} +: 4]),
    .ci (carry),
    .s  (sum_nib),
    .co (co_nib)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) state <= IDLE;
    else         state <= state_nx;
  end

  // last_gnt = 1 means requester 1 was granted last, so requester 0 wins a tie.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    last_pass = 1'b0;
    pick_1    = bus.req_1 && (!bus.req_0 || !last_gnt);
    case (state)
      IDLE: if (bus.req_0 || bus.req_1) begin
        start    = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == 3'd7) begin
        last_pass = 1'b1;
        state_nx  = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sub_reg  <= 1'b0;
      carry    <= 1'b0;
      result   <= '0;
      last_gnt <= 1'b1;
      gnt_0_r  <= 1'b0;
      gnt_1_r  <= 1'b0;
      q_r      <= '0;
      co_r     <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      if (start) begin
        a_reg    <= pick_1 ? bus.a_1 : bus.a_0;
        b_reg    <= pick_1 ? bus.b_1 : bus.b_0;
        sub_reg  <= pick_1 ? bus.sub_1 : bus.sub_0;
        carry    <= pick_1 ? bus.sub_1 : bus.sub_0;
        cnt      <= '0;
        result   <= '0;
        gnt_0_r  <= !pick_1;
        gnt_1_r  <= pick_1;
        last_gnt <= pick_1;
      end
      if (state == RUN) begin
        result[{cnt, 2'b00} +: 4] <= sum_nib;
        carry <= co_nib;
        cnt   <= cnt + 3'd1;
      end
      // Final pass: sum_nib is the top nibble, so q_new is the complete result.
      if (last_pass) begin
        q_r    <= q_new;
        co_r   <= co_nib;
        zero_r <= (q_new == 32'd0);
        ovf_r  <= (a_reg[31] == b_eff[31]) && (sum_nib[3] != a_reg[31]);
      end
      if (state == DONE) begin
        gnt_0_r <= 1'b0;
        gnt_1_r <= 1'b0;
      end
    end
  end

  assign bus.gnt_0 = gnt_0_r;
  assign bus.gnt_1 = gnt_1_r;
  assign bus.ack_0 = (state == DONE) && gnt_0_r;
  assign bus.ack_1 = (state == DONE) && gnt_1_r;
  assign bus.busy  = (state != IDLE);
  assign bus.q     = q_r;
  assign bus.co    = co_r;
  assign bus.ovf   = ovf_r;
  assign bus.zero  = zero_r;
endmodule

// File: tb/tb_j_addseq.sv
// Directed bench for j_addseq: vector table for arithmetic, hand sequences for
// reset, robustness and round-robin arbitration.
module tb_j_addseq;
  logic sys_clk = 1'b0;
  logic resetl;
  always #5 sys_clk = ~sys_clk;

  j_addseq_if bus ();
  j_addseq dut (.sys_clk(sys_clk), .resetl(resetl), .bus(bus));

  int total = 0;
  int bad   = 0;
  int excl_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    int          who;
    logic [31:0] q;
    logic        co;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs [8];

  always @(negedge sys_clk) begin
    if ((bus.gnt_0 && bus.gnt_1) || (bus.ack_0 && bus.ack_1)) begin
      excl_bad++;
      $display("FAIL exclusive: gnt=%b%b ack=%b%b required at most one of each",
               bus.gnt_1, bus.gnt_0, bus.ack_1, bus.ack_0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    bit got;
    if (v.who == 0) begin
      bus.a_0 = v.a; bus.b_0 = v.b; bus.sub_0 = v.sub; bus.req_0 = 1'b1;
    end else begin
      bus.a_1 = v.a; bus.b_1 = v.b; bus.sub_1 = v.sub; bus.req_1 = 1'b1;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 1) begin
        check("gnt_cycle1", 32'(v.who == 0 ? bus.gnt_0 : bus.gnt_1), 32'd1);
        check("busy_cycle1", 32'(bus.busy), 32'd1);
      end
      got = (v.who == 0) ? bus.ack_0 : bus.ack_1;
    end
    check("ack_cycle", 32'(cyc), 32'd9);
    check("q", bus.q, v.q);
    check("co", 32'(bus.co), 32'(v.co));
    check("ovf", 32'(bus.ovf), 32'(v.ovf));
    check("zero", 32'(bus.zero), 32'(v.zero));
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    step();
    check("busy_after", 32'(bus.busy), 32'd0);
    check("q_hold", bus.q, v.q);
  endtask

  initial begin
    int cyc, last_cyc, k;
    bit any_ack;

    vecs[0] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    resetl = 1'b0;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.a_0 = '0; bus.b_0 = '0; bus.a_1 = '0; bus.b_1 = '0;
    bus.sub_0 = 1'b0; bus.sub_1 = 1'b0;
    step();
    step();
    check("rst_gnt", {30'd0, bus.gnt_1, bus.gnt_0}, 32'd0);
    check("rst_ack", {30'd0, bus.ack_1, bus.ack_0}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_q", bus.q, 32'd0);
    check("rst_co_ovf", {30'd0, bus.co, bus.ovf}, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    @(negedge sys_clk);
    resetl = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Requester 1 drops req and changes operands mid-run; latched operands must be used.
    bus.a_1 = 32'd100; bus.b_1 = 32'd1; bus.sub_1 = 1'b0; bus.req_1 = 1'b1;
    cyc = 0;
    any_ack = 1'b0;
    while (!any_ack && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 3) begin
        bus.req_1 = 1'b0;
        bus.a_1   = 32'h0000_DEAD;
        bus.b_1   = 32'h1234_0000;
        bus.sub_1 = 1'b1;
      end
      any_ack = bus.ack_1;
    end
    check("robust_ack_cycle", 32'(cyc), 32'd9);
    check("robust_q", bus.q, 32'd101);
    step();

    // Reset in the middle of RUN.
    bus.a_0 = 32'd9; bus.b_0 = 32'd9; bus.sub_0 = 1'b0; bus.req_0 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("midrun_busy_before", 32'(bus.busy), 32'd1);
    #2;
    resetl = 1'b0;
    #1;
    check("midrun_gnt", {30'd0, bus.gnt_1, bus.gnt_0}, 32'd0);
    check("midrun_ack", {30'd0, bus.ack_1, bus.ack_0}, 32'd0);
    check("midrun_busy", 32'(bus.busy), 32'd0);
    check("midrun_q", bus.q, 32'd0);
    check("midrun_co_ovf", {30'd0, bus.co, bus.ovf}, 32'd0);
    check("midrun_zero", 32'(bus.zero), 32'd1);
    bus.req_0 = 1'b0;
    @(negedge sys_clk);
    resetl = 1'b1;
    any_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.ack_0 || bus.ack_1 || bus.busy) any_ack = 1'b1;
    end
    check("no_ack_after_reset", 32'(any_ack), 32'd0);

    // Both requesters held: grants alternate 0,1,0,1 with acks 10 cycles apart.
    bus.a_0 = 32'd1;  bus.b_0 = 32'd2; bus.sub_0 = 1'b0;
    bus.a_1 = 32'd10; bus.b_1 = 32'd3; bus.sub_1 = 1'b1;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1;
    cyc = 0; last_cyc = 0; k = 0;
    while (k < 4 && cyc < 60) begin
      step();
      cyc++;
      if (bus.ack_0 || bus.ack_1) begin
        check("arb_order", 32'(bus.ack_1), 32'(k % 2));
        check("arb_spacing", 32'(cyc - last_cyc), (k == 0) ? 32'd9 : 32'd10);
        check("arb_q", bus.q, (k % 2 == 0) ? 32'd3 : 32'd7);
        last_cyc = cyc;
        k++;
        if (k == 4) begin
          bus.req_0 = 1'b0;
          bus.req_1 = 1'b0;
        end
      end
    end
    check("arb_ack_count", 32'(k), 32'd4);
    step();
    step();
    check("arb_idle_after", 32'(bus.busy), 32'd0);

    check("gnt_ack_exclusive", 32'(excl_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
